// File: rtl/spi_master_pkg.sv
// Shared definitions for the internal SPI master driving the 4094 chain and the DAC.
package spi_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StLatch,
    StDone
  } state_e;

  localparam logic TGT_4094 = 1'b0;
  localparam logic TGT_DAC  = 1'b1;

  // Bits needed to hold the values 0..n.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: asserts tick on the last cycle of every CLK_DIV-cycle window.
module spi_tick_gen
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned TW = cnt_bits(CLK_DIV);
  localparam logic [TW-1:0] LOAD = TW'(CLK_DIV - 1);

  logic [TW-1:0] cnt_q;

  assign tick = (cnt_q == '0);

  // Reloading on tick starts each new window without needing an explicit clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else if (clear || tick) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

endmodule

// File: rtl/spi_master_4094.sv
// SPI initiator for the 4094 shift-register chain (strobed) and the SPI DAC (cs_n framed).
module spi_master_4094
  import spi_master_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             target_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             sclk_o,
  output logic             mosi_o,
  input  logic             miso_i,
  output logic             strobe_o,
  output logic             cs_n_o
);

  localparam int unsigned BW = cnt_bits(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q;
  logic             tgt_q;
  logic             half_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] cap_nxt;
  logic             tick;
  logic             tick_clear;

  assign shift_nxt  = shift_q << 1;
  assign cap_nxt    = (cap_q << 1) | WIDTH'(miso_i);
  // Hold the divider at its reload value whenever no timed phase is running.
  assign tick_clear = (state_q == StIdle) || (state_q == StDone);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tgt_q     <= TGT_4094;
      half_q    <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cap_q     <= '0;
      data_o    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      sclk_o    <= 1'b1;
      mosi_o    <= 1'b1;
      strobe_o  <= 1'b0;
      cs_n_o    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StSetup;
            shift_q <= data_i;
            tgt_q   <= target_i;
            busy_o  <= 1'b1;
            mosi_o  <= data_i[WIDTH-1];
            cs_n_o  <= (target_i != TGT_DAC);
          end
        end
        StSetup: begin
          if (tick) begin
            state_q   <= StShift;
            sclk_o    <= 1'b0;
            half_q    <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        StShift: begin
          if (tick) begin
            if (!half_q) begin
              // Rising SCLK: capture the chain's serial output.
              sclk_o <= 1'b1;
              half_q <= 1'b1;
              cap_q  <= cap_nxt;
            end else if (bit_cnt_q == LAST_BIT) begin
              state_q  <= StLatch;
              mosi_o   <= 1'b1;
              cs_n_o   <= 1'b1;
              strobe_o <= (tgt_q == TGT_4094);
            end else begin
              sclk_o    <= 1'b0;
              half_q    <= 1'b0;
              bit_cnt_q <= bit_cnt_q + BW'(1);
              shift_q   <= shift_nxt;
              mosi_o    <= shift_nxt[WIDTH-1];
            end
          end
        end
        StLatch: begin
          if (tick) begin
            state_q  <= StDone;
            strobe_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            data_o   <= cap_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_o  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_4094.sv
// Self-checking bench: three configurations checked cycle by cycle against a timeline model.
module tb_spi_master_4094;
  import spi_master_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  start_v, tgt_v;
  logic [31:0] din [3];
  logic [2:0]  sclk_v, mosi_v, cs_v, stb_v, busy_v, done_v;
  logic [7:0]  dout0;
  logic [31:0] dout1;
  logic [15:0] dout2;
  logic        rd_mode, pl_strobe;
  logic [7:0]  preload, chain;
  wire         miso0 = rd_mode ? chain[7] : mosi_v[0];

  int checks = 0;
  int failures = 0;

  spi_master_4094 #(.WIDTH(8), .CLK_DIV(2)) u0 (
    .clk(clk), .reset(reset), .start_i(start_v[0]), .target_i(tgt_v[0]),
    .data_i(din[0][7:0]), .data_o(dout0), .busy_o(busy_v[0]), .done_o(done_v[0]),
    .sclk_o(sclk_v[0]), .mosi_o(mosi_v[0]), .miso_i(miso0), .strobe_o(stb_v[0]),
    .cs_n_o(cs_v[0])
  );

  spi_master_4094 #(.WIDTH(32), .CLK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .start_i(start_v[1]), .target_i(tgt_v[1]),
    .data_i(din[1]), .data_o(dout1), .busy_o(busy_v[1]), .done_o(done_v[1]),
    .sclk_o(sclk_v[1]), .mosi_o(mosi_v[1]), .miso_i(mosi_v[1]), .strobe_o(stb_v[1]),
    .cs_n_o(cs_v[1])
  );

  spi_master_4094 #(.WIDTH(16), .CLK_DIV(7)) u2 (
    .clk(clk), .reset(reset), .start_i(start_v[2]), .target_i(tgt_v[2]),
    .data_i(din[2][15:0]), .data_o(dout2), .busy_o(busy_v[2]), .done_o(done_v[2]),
    .sclk_o(sclk_v[2]), .mosi_o(mosi_v[2]), .miso_i(mosi_v[2]), .strobe_o(stb_v[2]),
    .cs_n_o(cs_v[2])
  );

  // Model 4094 chain: serial out is its MSB, shifts on SCLK rise.
  always @(posedge sclk_v[0] or posedge pl_strobe) begin
    if (pl_strobe) chain <= preload;
    else           chain <= {chain[6:0], mosi_v[0]};
  end

  function automatic int wof(input int i);
    case (i)
      0:       return 8;
      1:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int hof(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic logic [31:0] mask(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] dout(input int i);
    case (i)
      0:       return {24'b0, dout0};
      1:       return dout1;
      default: return {16'b0, dout2};
    endcase
  endfunction

  function automatic string sig_name(input int k);
    case (k)
      0:       return "done";
      1:       return "busy";
      2:       return "strobe";
      3:       return "cs_n";
      4:       return "mosi";
      default: return "sclk";
    endcase
  endfunction

  // Expected {sclk, mosi, cs_n, strobe, busy, done} at cycle t after start was sampled.
  function automatic logic [5:0] exp_bus(input int w, input int h, input bit run, input int t,
                                         input logic [31:0] word, input logic tg);
    logic sclk, mosi, csn, stb, busy, done;
    int   e, sh, u;
    sclk = 1'b1; mosi = 1'b1; csn = 1'b1; stb = 1'b0; busy = 1'b0; done = 1'b0;
    e  = h * (2 * w + 2);
    sh = h + 2 * h * w;
    if (run) begin
      if (t < h) begin
        busy = 1'b1;
        mosi = word[w-1];
        csn  = (tg != TGT_DAC);
      end else if (t < sh) begin
        u    = t - h;
        busy = 1'b1;
        sclk = ((u % (2 * h)) >= h);
        mosi = word[w - 1 - u / (2 * h)];
        csn  = (tg != TGT_DAC);
      end else if (t < e) begin
        busy = 1'b1;
        stb  = (tg == TGT_4094);
      end else begin
        done = 1'b1;
      end
    end
    return {sclk, mosi, csn, stb, busy, done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 50) $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Model state
  bit          run [3];
  int          tt [3];
  logic [31:0] mword [3], mcap [3], mexp [3];
  logic        mtg [3];

  task automatic model_step();
    logic [5:0] e, a;
    int         last;
    for (int i = 0; i < 3; i++) begin
      last = hof(i) * (2 * wof(i) + 2);
      if (reset) begin
        run[i]  = 1'b0;
        mexp[i] = '0;
      end else if (run[i] && tt[i] == last) begin
        mexp[i] = mcap[i];
      end
      e = exp_bus(wof(i), hof(i), run[i], tt[i], mword[i], mtg[i]);
      a = {sclk_v[i], mosi_v[i], cs_v[i], stb_v[i], busy_v[i], done_v[i]};
      for (int k = 0; k < 6; k++)
        chk($sformatf("u%0d.%s run=%0d t=%0d", i, sig_name(k), run[i], tt[i]),
            32'(a[k]), 32'(e[k]));
      chk($sformatf("u%0d.data_o t=%0d", i, tt[i]), dout(i), mexp[i]);
      if (!reset) begin
        if (run[i]) begin
          if (tt[i] == last) run[i] = 1'b0;
          else               tt[i]++;
        end else if (start_v[i]) begin
          run[i]   = 1'b1;
          tt[i]    = 0;
          mword[i] = din[i] & mask(wof(i));
          mtg[i]   = tgt_v[i];
          mcap[i]  = (i == 0 && rd_mode) ? {24'b0, preload} : mword[i];
        end
      end
    end
  endtask

  // Cumulative activity counters; tests take differences around each transfer.
  int          busy_tot [3], done_tot [3], stb_tot [3], csl_tot [3], rise_tot [3], csbad_tot [3];
  logic [31:0] mosi_acc [3];
  logic        prev_sclk [3], prev_cs [3];

  task automatic mon_step();
    for (int i = 0; i < 3; i++) begin
      busy_tot[i] += int'(busy_v[i]);
      done_tot[i] += int'(done_v[i]);
      stb_tot[i]  += int'(stb_v[i]);
      csl_tot[i]  += int'(!cs_v[i]);
      if (sclk_v[i] && !prev_sclk[i]) begin
        rise_tot[i]++;
        mosi_acc[i] = {mosi_acc[i][30:0], mosi_v[i]};
      end
      if (cs_v[i] && !prev_cs[i] && !sclk_v[i]) csbad_tot[i]++;
      prev_sclk[i] = sclk_v[i];
      prev_cs[i]   = cs_v[i];
    end
  endtask

  int s_busy, s_done, s_stb, s_csl, s_rise, s_csbad;

  task automatic snap(input int i);
    s_busy = busy_tot[i]; s_done = done_tot[i]; s_stb = stb_tot[i];
    s_csl = csl_tot[i]; s_rise = rise_tot[i]; s_csbad = csbad_tot[i];
  endtask

  task automatic setup_xfer(input int i, input logic [31:0] d, input logic tg, input logic rd,
                            input logic [7:0] pl);
    din[i]   = d;
    tgt_v[i] = tg;
    if (i == 0) begin
      rd_mode   = rd;
      preload   = pl;
      pl_strobe = 1'b1;
      #1 pl_strobe = 1'b0;
    end
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #2 start_v[i] = 1'b1;
    @(posedge clk); #2 start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit);
    int n;
    n = 0;
    while (!done_v[i] && n < limit) begin
      @(posedge clk); #3;
      n++;
    end
    chk($sformatf("u%0d.done_seen", i), 32'(done_v[i]), 32'd1);
    @(posedge clk); #3;
  endtask

  task automatic stimulus();
    logic [31:0] d;
    // Reset state
    repeat (3) @(posedge clk);
    #3;
    chk("rst.sclk", 32'(sclk_v[0]), 32'd1);
    chk("rst.mosi", 32'(mosi_v[0]), 32'd1);
    chk("rst.strobe", 32'(stb_v[0]), 32'd0);
    chk("rst.cs_n", 32'(cs_v[0]), 32'd1);
    chk("rst.busy", 32'(busy_v[0]), 32'd0);
    chk("rst.data_o", dout(0), 32'd0);
    @(posedge clk); #2 reset = 1'b0;

    // 4094 write, loopback
    snap(0);
    setup_xfer(0, 32'hA5, TGT_4094, 1'b0, 8'h00);
    pulse_start(0);
    wait_done(0, 200);
    chk("a5.busy_cycles", 32'(busy_tot[0] - s_busy), 32'd36);
    chk("a5.sclk_rises", 32'(rise_tot[0] - s_rise), 32'd8);
    chk("a5.mosi_bits", {24'b0, mosi_acc[0][7:0]}, 32'hA5);
    chk("a5.strobe_cycles", 32'(stb_tot[0] - s_stb), 32'd2);
    chk("a5.cs_low_cycles", 32'(csl_tot[0] - s_csl), 32'd0);
    chk("a5.done_pulses", 32'(done_tot[0] - s_done), 32'd1);
    chk("a5.data_o", dout(0), 32'hA5);

    // DAC write
    snap(0);
    setup_xfer(0, 32'h3C, TGT_DAC, 1'b0, 8'h00);
    pulse_start(0);
    wait_done(0, 200);
    chk("dac.cs_low_cycles", 32'(csl_tot[0] - s_csl), 32'd34);
    chk("dac.strobe_cycles", 32'(stb_tot[0] - s_stb), 32'd0);
    chk("dac.sclk_rises", 32'(rise_tot[0] - s_rise), 32'd8);
    chk("dac.cs_rise_sclk_low", 32'(csbad_tot[0] - s_csbad), 32'd0);
    chk("dac.data_o", dout(0), 32'h3C);

    // Readback from preloaded chain
    setup_xfer(0, 32'h5A, TGT_4094, 1'b1, 8'h96);
    pulse_start(0);
    wait_done(0, 200);
    chk("rdbk.data_o", dout(0), 32'h96);

    // Start while busy is ignored
    snap(0);
    setup_xfer(0, 32'h4B, TGT_4094, 1'b0, 8'h00);
    pulse_start(0);
    repeat (10) @(posedge clk);
    #2 start_v[0] = 1'b1;
    @(posedge clk); #2 start_v[0] = 1'b0;
    wait_done(0, 200);
    chk("busy_start.done_pulses", 32'(done_tot[0] - s_done), 32'd1);
    snap(0);
    repeat (20) @(posedge clk);
    #3;
    chk("busy_start.stays_idle", 32'(busy_tot[0] - s_busy), 32'd0);

    // Reset during bit 4 of SHIFT
    snap(0);
    setup_xfer(0, 32'hC3, TGT_4094, 1'b0, 8'h00);
    pulse_start(0);
    repeat (19) @(posedge clk);
    #1;
    chk("rstmid.sclk_before", 32'(sclk_v[0]), 32'd0);
    reset = 1'b1;
    #1;
    chk("rstmid.sclk", 32'(sclk_v[0]), 32'd1);
    chk("rstmid.mosi", 32'(mosi_v[0]), 32'd1);
    chk("rstmid.strobe", 32'(stb_v[0]), 32'd0);
    chk("rstmid.cs_n", 32'(cs_v[0]), 32'd1);
    chk("rstmid.busy", 32'(busy_v[0]), 32'd0);
    chk("rstmid.done", 32'(done_v[0]), 32'd0);
    chk("rstmid.data_o", dout(0), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    chk("rstmid.no_strobe", 32'(stb_tot[0] - s_stb), 32'd0);
    chk("rstmid.no_done", 32'(done_tot[0] - s_done), 32'd0);
    setup_xfer(0, 32'h69, TGT_DAC, 1'b0, 8'h00);
    pulse_start(0);
    wait_done(0, 200);
    chk("rstmid.after_data_o", dout(0), 32'h69);

    // Randomised transfers with occasional stray starts
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
      setup_xfer(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom));
      pulse_start(0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #2 start_v[0] = 1'b1;
        @(posedge clk); #2 start_v[0] = 1'b0;
      end
      wait_done(0, 200);
    end

    // Parameter sweep, loopback
    for (int i = 1; i < 3; i++) begin
      for (int n = 0; n < 2; n++) begin
        d = $urandom;
        snap(i);
        setup_xfer(i, d, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        pulse_start(i);
        wait_done(i, 600);
        chk($sformatf("sweep%0d.busy_cycles", i), 32'(busy_tot[i] - s_busy),
            (i == 1) ? 32'd66 : 32'd238);
        chk($sformatf("sweep%0d.sclk_rises", i), 32'(rise_tot[i] - s_rise),
            (i == 1) ? 32'd32 : 32'd16);
        chk($sformatf("sweep%0d.data_o", i), dout(i), d & mask(wof(i)));
      end
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    start_v   = '0;
    tgt_v     = '0;
    rd_mode   = 1'b0;
    pl_strobe = 1'b0;
    preload   = '0;
    for (int i = 0; i < 3; i++) begin
      din[i]       = '0;
      run[i]       = 1'b0;
      tt[i]        = 0;
      mword[i]     = '0;
      mcap[i]      = '0;
      mexp[i]      = '0;
      mtg[i]       = 1'b0;
      busy_tot[i]  = 0;
      done_tot[i]  = 0;
      stb_tot[i]   = 0;
      csl_tot[i]   = 0;
      rise_tot[i]  = 0;
      csbad_tot[i] = 0;
      mosi_acc[i]  = '0;
      prev_sclk[i] = 1'b1;
      prev_cs[i]   = 1'b1;
    end
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
      forever begin
        @(negedge clk);
        mon_step();
      end
      stimulus();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_4094.md
Name: spi_master_4094

Overview:
- FPGA-side SPI initiator for the on-board 4094 shift-register chain and the SPI DAC.
- Lets on-chip sequencing logic update 4094 outputs and DAC codes without the MCU.
- Drives the GLB_SPI_CLK, GLB_SPI_MOSI, GLB_4094_STROBE_CTL and SPI_DAC_SS nets, and captures readback from U1004_4094_DATA.
- Sits in top beside the MCU passthrough mux; top selects this block's pins when the mux selects the internal master.

Parameters:
- WIDTH, 32: bits per transfer, shifted MSB first.
- CLK_DIV, 4: half-period of SCLK in clk cycles; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  request a transfer; sampled only in IDLE.
- target_i  in  1  0 = 4094 chain (strobe after shift), 1 = DAC (cs_n framing only); latched at start.
- data_i  in  WIDTH  word to transmit; latched at start.
- data_o  out  WIDTH  word captured from miso_i; updated at transfer end.
- busy_o  out  1  high from SETUP through LATCH.
- done_o  out  1  one-cycle pulse when transfer completes.
- sclk_o  out  1  SPI clock; parks high.
- mosi_o  out  1  SPI data out; parks high.
- miso_i  in  1  SPI data in (4094 chain serial out).
- strobe_o  out  1  4094 strobe, active high.
- cs_n_o  out  1  DAC select, active low.

Behaviour:
- Reset values: sclk_o=1, mosi_o=1, strobe_o=0, cs_n_o=1, busy_o=0, done_o=0, data_o=0, state=IDLE.
- Reset asserted mid-transfer returns all outputs to these values immediately. No partial strobe; the partially shifted word is discarded.
- H denotes CLK_DIV. The tick counter restarts at 0 on every state entry.
- IDLE:
  - When start_i=1, latch data_i into the shift register and latch target_i.
  - Next state SETUP.
  - start_i while not in IDLE is ignored; no queueing.
- SETUP (H cycles):
  - busy_o=1 and sclk_o=1.
  - mosi_o = shift register MSB.
  - cs_n_o=0 if target=DAC; cs_n_o stays 1 if target=4094.
- SHIFT (2·H·WIDTH cycles), per bit:
  - First H cycles: sclk_o=0.
  - Next H cycles: sclk_o=1.
  - miso_i is sampled on the clk edge where sclk_o goes 0→1 and shifted into the capture register's LSB.
  - The shift register advances, and mosi_o presents the next bit, on the 1→0 sclk transition.
  - A bit counter runs 0..WIDTH-1. After the last high half, sclk_o stays 1 and mosi_o returns to 1.
- LATCH (H cycles):
  - cs_n_o=1.
  - strobe_o=1 if target=4094; strobe_o=0 if target=DAC.
- DONE (1 cycle):
  - busy_o=0, done_o=1.
  - data_o ← capture register.
  - Next state IDLE. start_i is not accepted in DONE.
- Latency: start_i sampled at edge k gives busy_o high for cycles k+1 .. k+2H+2HW+... ; specifically busy_o is high for exactly H·(2·WIDTH+2) cycles, and done_o is high in the following cycle.
- Bus state when idle: sclk_o and mosi_o are never 0 in IDLE or DONE.
- strobe_o is never high while sclk_o toggles. cs_n_o is never low outside SETUP/SHIFT.
- Counters: tick counter is clog2(CLK_DIV+1) bits; bit counter is clog2(WIDTH+1) bits. No wrap within a transfer.

Decomposition:
- Shared package spi_master_pkg:
  - State encoding: IDLE, SETUP, SHIFT, LATCH, DONE.
  - Target constants: TGT_4094=0, TGT_DAC=1.
- One sub-module, spi_tick_gen:
  - Parameterised down-counter producing a half-period tick.
  - Cleared on state change.

Test Plan (WIDTH=8, CLK_DIV=2 unless stated):
- 4094 write:
  - Stimulus: data_i=0xA5, target 0, miso_i tied to mosi_o.
  - Response: mosi bit sequence 1,0,1,0,0,1,0,1 at sclk rising edges; busy_o high 36 cycles; strobe_o high 2 cycles after the last sclk rise; cs_n_o stays 1; done_o pulses once; data_o=0xA5.
- DAC write:
  - Stimulus: data_i=0x3C, target 1.
  - Response: cs_n_o low 34 cycles, covering SETUP plus SHIFT; strobe_o never high; 8 sclk rising edges; sclk_o=1 while cs_n_o rises.
- Readback:
  - Stimulus: miso_i driven from a model 4094 chain preloaded with 0x96.
  - Response: data_o=0x96 after done_o.
- Start while busy:
  - Stimulus: pulse start_i at cycle 10 of a transfer.
  - Response: ignored; exactly one done_o; next transfer begins only after a start_i pulse in IDLE.
- Reset mid-SHIFT:
  - Stimulus: assert reset at bit 4.
  - Response: outputs at reset values in the same cycle (asynchronous); no strobe_o pulse; data_o=0; a new transfer after release completes normally.
- Parameter sweep:
  - Stimulus: CLK_DIV=1 with WIDTH=32, and CLK_DIV=7 with WIDTH=16.
  - Response: busy_o length equals CLK_DIV·(2·WIDTH+2) cycles; loopback data_o equals data_i.
